// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM state codes and iteration count for the mul/div unit.
package muldiv_pkg;
    localparam int WIDTH_DEFAULT = 32;
    localparam int ITER = WIDTH_DEFAULT;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiply / restoring divide datapath.
// Ports: clk, rst (async high); load captures unsigned operands a_in/b_in, step runs one
// iteration, mode selects divide (1) or multiply (0); prod is the 2*WIDTH product,
// quo/rem the quotient and remainder.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem
);
    // acc holds {partial product, multiplier} when multiplying and {0, dividend/quotient}
    // when dividing; opnd is the multiplicand or the divisor.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem_r, opnd;
    logic [WIDTH:0]     sum, shifted, diff;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted = {rem_r, acc[WIDTH-1]};
        // the restored remainder stays below the divisor, so diff[WIDTH] is the borrow
        diff    = shifted - {1'b0, opnd};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            rem_r <= '0;
            opnd  <= '0;
        end else if (load) begin
            acc   <= {{WIDTH{1'b0}}, mode ? a_in : b_in};
            opnd  <= mode ? b_in : a_in;
            rem_r <= '0;
        end else if (step) begin
            if (!mode) begin
                acc <= {sum, acc[WIDTH-1:1]};
            end else begin
                acc   <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]};
                rem_r <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            end
        end
    end

    assign prod = acc;
    assign quo  = acc[WIDTH-1:0];
    assign rem  = rem_r;
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with pipeline stall request.
// Ports: clk, rst (async high); start/op/a/b issue an op in IDLE; mf_req, hi_we/lo_we/wdata are
// MFHI/MFLO and MTHI/MTLO requests; hi/lo architectural registers; busy, done pulse, divz
// (divide by zero, qualifies done), stall_req toward the pipeline controller.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_req,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divz,
    output logic             stall_req
);
    localparam int CW = $clog2(ITER);

    logic [1:0]         state, op_r;
    logic [WIDTH-1:0]   a_r, b_r, a_mag, b_mag, quo, rem, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [CW-1:0]      count;
    logic               neg_q, neg_r, is_div, is_signed, bz;

    assign is_div    = op_r[1];
    assign is_signed = ~op_r[0];
    assign bz        = b_r == '0;
    // -0x80000000 wraps to itself, which read as unsigned is the correct magnitude
    assign a_mag     = (is_signed & a_r[WIDTH-1]) ? -a_r : a_r;
    assign b_mag     = (is_signed & b_r[WIDTH-1]) ? -b_r : b_r;
    assign prod_fix  = neg_q ? -prod : prod;
    assign quo_fix   = neg_q ? -quo : quo;
    assign rem_fix   = neg_r ? -rem : rem;
    assign busy      = state != IDLE;
    assign stall_req = busy & (start | mf_req | hi_we | lo_we);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk  (clk),
        .rst  (rst),
        .load (state == PREP),
        .step (state == RUN),
        .mode (is_div),
        .a_in (a_mag),
        .b_in (b_mag),
        .prod (prod),
        .quo  (quo),
        .rem  (rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            divz  <= 1'b0;
        end else begin
            done <= 1'b0;
            divz <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        state <= PREP;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                PREP: begin
                    neg_q <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r <= is_signed & a_r[WIDTH-1];
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == CW'(ITER - 1)) state <= FIX;
                end
                default: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (bz) begin
                        hi   <= a_r;
                        lo   <= '1;
                        divz <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scoreboard bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        mf_req = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done, divz, stall_req;

    int tests = 0;
    int fails = 0;
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mf_req(mf_req), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .divz(divz), .stall_req(stall_req)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                check("hi", 64'(hi), 64'(e[64:33]));
                check("lo", 64'(lo), 64'(e[32:1]));
                check("divz", 64'(divz), 64'(e[0]));
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez);
        int n;
        int bad_busy;
        exp_q.push_back({eh, el, ez});
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        bad_busy = 0;
        while (n < 100) begin
            @(negedge clk);
            if (done) break;
            if (!busy) bad_busy++;
            n++;
        end
        check("latency", 64'(n), 64'd35);
        check("busy_window", 64'(bad_busy), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        mf_req = 1'b1;
        #12;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_divz", 64'(divz), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        mf_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op(2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op(2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1);
        run_op(2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
        run_op(2'b00, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);

        // MULT in flight: stall requests, ignored start, then reset abort
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        mf_req = 1'b1;
        @(negedge clk);
        check("stall_mf", 64'(stall_req), 64'd1);
        @(posedge clk); #1;
        mf_req = 1'b0;
        @(negedge clk);
        check("stall_idle_req", 64'(stall_req), 64'd0);
        check("busy_mid", 64'(busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
        @(negedge clk);
        check("stall_start", 64'(stall_req), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_idle", 64'(busy), 64'd0);

        lo_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        @(negedge clk);
        check("mtlo", 64'(lo), 64'h1234);
        check("mtlo_hi", 64'(hi), 64'd0);

        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'hDEAD;
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
        exp_q.push_back({32'd0, 32'd6, 1'b0});
        @(posedge clk); #1;
        hi_we = 1'b0; start = 1'b0;
        @(negedge clk);
        check("mt_dropped", 64'(hi), 64'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
